// File: rtl/fpa_pkg.sv
// Shared types and width helpers for the pipelined floating-point adder.
// Widths are derived from the exponent/mantissa field sizes of the instance.
package fpa_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

    // Extended mantissa layout: {hidden, mantissa, guard, round, sticky}
    localparam int GRS_W = 3;
    localparam int G_POS = 2;
    localparam int R_POS = 1;
    localparam int S_POS = 0;

    function automatic int ext_w(input int man_w);
        return man_w + 1 + GRS_W;
    endfunction

    function automatic int sum_w(input int man_w);
        return ext_w(man_w) + 1;
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Quiet NaN with sign 0, exponent all ones and only the top mantissa bit set.
    function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpa_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpa_lzc #(
    parameter int WIDTH = 28,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpa_pipe.sv
// Three-stage floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero on subnormal inputs, IEEE exception flags and a stall-all handshake.
module fpa_pipe
    import fpa_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int TOTAL_W = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] number_A,
    input  logic [TOTAL_W-1:0] number_B,
    input  logic               op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] number_out,
    output logic               flag_invalid,
    output logic               flag_overflow,
    output logic               flag_underflow,
    output logic               flag_inexact
);

    localparam int EXT_W = ext_w(MAN_W);
    localparam int SUM_W = sum_w(MAN_W);
    localparam int CNT_W = cnt_w(SUM_W);
    localparam int MAG_W = EXP_W + MAN_W;
    localparam int XW    = max_i(EXP_W, CNT_W) + 2;

    localparam logic [127:0]        NAN_WIDE = canon_nan(EXP_W, MAN_W);
    localparam logic [TOTAL_W-1:0]  NAN_VAL  = NAN_WIDE[TOTAL_W-1:0];
    localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);

    function automatic fp_class_t classify(input logic [TOTAL_W-1:0] v);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = v[TOTAL_W-2:MAN_W];
        m = v[MAN_W-1:0];
        if (e == '0)      return ZERO;
        else if (e == '1) return (m == '0) ? INF : NAN;
        else              return NORMAL;
    endfunction

    // Valid/ready: a transfer happens on in_valid & in_ready or out_valid & out_ready;
    // all stages advance together whenever the output slot is empty or being drained.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: classify, swap, align ----------------
    logic [TOTAL_W-1:0] op_a, op_b;
    logic               sa, sb;
    fp_class_t          cls_a, cls_b;
    logic [MAG_W-1:0]   mag_a, mag_b, big_mag, small_mag;
    logic               a_big;
    logic [EXP_W-1:0]   exp_big, exp_small, diff;
    logic [EXT_W-1:0]   big_ext, small_ext, small_aln;

    assign op_a  = number_A;
    assign op_b  = {number_B[TOTAL_W-1] ^ op_sub, number_B[TOTAL_W-2:0]};
    assign sa    = op_a[TOTAL_W-1];
    assign sb    = op_b[TOTAL_W-1];
    assign cls_a = classify(op_a);
    assign cls_b = classify(op_b);

    // Zero-class operands (including flushed subnormals) take part as exact zeros.
    assign mag_a     = (cls_a == ZERO) ? '0 : op_a[MAG_W-1:0];
    assign mag_b     = (cls_b == ZERO) ? '0 : op_b[MAG_W-1:0];
    assign a_big     = (mag_a >= mag_b);
    assign big_mag   = a_big ? mag_a : mag_b;
    assign small_mag = a_big ? mag_b : mag_a;
    assign exp_big   = big_mag[MAG_W-1:MAN_W];
    assign exp_small = small_mag[MAG_W-1:MAN_W];
    assign diff      = exp_big - exp_small;
    assign big_ext   = {|exp_big, big_mag[MAN_W-1:0], {GRS_W{1'b0}}};
    assign small_ext = {|exp_small, small_mag[MAN_W-1:0], {GRS_W{1'b0}}};

    always_comb begin
        small_aln = '0;
        if (int'(diff) >= EXT_W - 1) begin
            small_aln = {{(EXT_W-1){1'b0}}, |small_ext};
        end else begin
            small_aln = (small_ext >> diff) |
                        {{(EXT_W-1){1'b0}}, |(small_ext & ~({EXT_W{1'b1}} << diff))};
        end
    end

    logic               byp;
    logic [TOTAL_W-1:0] byp_val;
    logic               byp_inv;

    always_comb begin
        byp     = 1'b1;
        byp_val = '0;
        byp_inv = 1'b0;
        if (cls_a == NAN || cls_b == NAN) begin
            byp_val = NAN_VAL;
            byp_inv = 1'b1;
        end else if (cls_a == INF && cls_b == INF && sa != sb) begin
            byp_val = NAN_VAL;
            byp_inv = 1'b1;
        end else if (cls_a == INF) begin
            byp_val = op_a;
        end else if (cls_b == INF) begin
            byp_val = op_b;
        end else if (cls_a == ZERO && cls_b == ZERO) begin
            byp_val = {sa & sb, {(TOTAL_W-1){1'b0}}};
        end else begin
            byp = 1'b0;
        end
    end

    logic               s1_valid, s1_byp, s1_byp_inv, s1_sign, s1_sub;
    logic [TOTAL_W-1:0] s1_byp_val;
    logic [EXP_W-1:0]   s1_exp;
    logic [EXT_W-1:0]   s1_big, s1_small;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_byp     <= 1'b0;
            s1_byp_inv <= 1'b0;
            s1_byp_val <= '0;
            s1_sign    <= 1'b0;
            s1_sub     <= 1'b0;
            s1_exp     <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
        end else if (en) begin
            s1_valid   <= in_valid;
            s1_byp     <= byp;
            s1_byp_inv <= byp_inv;
            s1_byp_val <= byp_val;
            s1_sign    <= a_big ? sa : sb;
            s1_sub     <= sa ^ sb;
            s1_exp     <= exp_big;
            s1_big     <= big_ext;
            s1_small   <= small_aln;
        end
    end

    // ---------------- S2: add/subtract, leading-zero count ----------------
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] lz;

    assign sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                        : ({1'b0, s1_big} + {1'b0, s1_small});

    fpa_lzc #(
        .WIDTH(SUM_W),
        .CNT_W(CNT_W)
    ) u_lzc (
        .value(sum),
        .count(lz)
    );

    logic               s2_valid, s2_byp, s2_byp_inv, s2_sign;
    logic [TOTAL_W-1:0] s2_byp_val;
    logic [EXP_W-1:0]   s2_exp;
    logic [SUM_W-1:0]   s2_sum;
    logic [CNT_W-1:0]   s2_lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_byp     <= 1'b0;
            s2_byp_inv <= 1'b0;
            s2_byp_val <= '0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_lz      <= '0;
        end else if (en) begin
            s2_valid   <= s1_valid;
            s2_byp     <= s1_byp;
            s2_byp_inv <= s1_byp_inv;
            s2_byp_val <= s1_byp_val;
            s2_sign    <= s1_sign;
            s2_exp     <= s1_exp;
            s2_sum     <= sum;
            s2_lz      <= lz;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [EXT_W-1:0]        norm;
    logic signed [XW-1:0]    exp_n, exp_r;
    logic                    lsb, g, r, s, round_up, rnd_carry;
    logic [MAN_W-1:0]        man_rnd;
    logic [TOTAL_W-1:0]      res;
    logic                    res_inv, res_ov, res_uf, res_inx;

    always_comb begin
        // A carry-out has no leading zeros, so exp + 1 - lz covers both directions.
        exp_n = XW'(s2_exp) + XW'(1) - XW'(s2_lz);
        if (s2_sum[SUM_W-1]) norm = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
        else                 norm = EXT_W'(s2_sum << (s2_lz - CNT_W'(1)));

        lsb      = norm[GRS_W];
        g        = norm[G_POS];
        r        = norm[R_POS];
        s        = norm[S_POS];
        round_up = g & (r | s | lsb);
        {rnd_carry, man_rnd} = {1'b0, norm[EXT_W-2:GRS_W]} + {{MAN_W{1'b0}}, round_up};
        exp_r = exp_n + XW'(rnd_carry);

        res     = '0;
        res_inv = 1'b0;
        res_ov  = 1'b0;
        res_uf  = 1'b0;
        res_inx = 1'b0;
        if (s2_byp) begin
            res     = s2_byp_val;
            res_inv = s2_byp_inv;
        end else if (!norm[EXT_W-1]) begin
            // Exact cancellation: nothing left after normalising.
            res = '0;
        end else if (exp_r >= EXP_TOP) begin
            res     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_ov  = 1'b1;
            res_inx = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res     = {s2_sign, {(TOTAL_W-1){1'b0}}};
            res_uf  = 1'b1;
            res_inx = 1'b1;
        end else begin
            res     = {s2_sign, exp_r[EXP_W-1:0], man_rnd};
            res_inx = g | r | s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            number_out     <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                number_out     <= res;
                flag_invalid   <= res_inv;
                flag_overflow  <= res_ov;
                flag_underflow <= res_uf;
                flag_inexact   <= res_inx;
            end
        end
    end

endmodule
